// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, drives the instruction-memory busywait handshake and
// registers the IF/ID boundary, with a one-entry stall buffer and redirect squash.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        BRANCH_TAKEN,
   input  logic [31:0] BRANCH_TARGET,
   output logic [31:0] IMEM_ADDR,
   output logic        IMEM_READ,
   input  logic        IMEM_BUSYWAIT,
   input  logic [31:0] IMEM_READDATA,
   output logic [31:0] INSTRUCTION,
   output logic [31:0] PC_OUT,
   output logic [31:0] PC_PLUS4,
   output logic        VALID
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] redir_pc_q, redir_pc_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        valid_q, valid_d;
   logic [31:0] target;

   assign target      = {BRANCH_TARGET[31:2], 2'b00};
   assign IMEM_ADDR   = pc_q;
   assign IMEM_READ   = ((state_q == FETCH) || (state_q == DROP)) && !RESET;
   assign INSTRUCTION = instr_q;
   assign PC_OUT      = pc_out_q;
   assign PC_PLUS4    = pc_plus4_q;
   assign VALID       = valid_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         redir_pc_q  <= '0;
         buf_instr_q <= '0;
         buf_pc_q    <= '0;
         instr_q     <= NOP_INSTR;
         pc_out_q    <= '0;
         pc_plus4_q  <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         redir_pc_q  <= redir_pc_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
         instr_q     <= instr_d;
         pc_out_q    <= pc_out_d;
         pc_plus4_q  <= pc_plus4_d;
         valid_q     <= valid_d;
      end
   end

   // Whenever VALID falls, INSTRUCTION is forced to the NOP so ID never decodes stale words.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      redir_pc_d  = redir_pc_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      instr_d     = instr_q;
      pc_out_d    = pc_out_q;
      pc_plus4_d  = pc_plus4_q;
      valid_d     = valid_q;

      case (state_q)
         FETCH: begin
            if (IMEM_BUSYWAIT) begin
               if (BRANCH_TAKEN) begin
                  redir_pc_d = target;
                  valid_d    = 1'b0;
                  instr_d    = NOP_INSTR;
                  state_d    = DROP;
               end else if (!STALL) begin
                  valid_d = 1'b0;
                  instr_d = NOP_INSTR;
               end
            end else begin
               if (BRANCH_TAKEN) begin
                  pc_d    = target;
                  valid_d = 1'b0;
                  instr_d = NOP_INSTR;
               end else if (!STALL) begin
                  instr_d    = IMEM_READDATA;
                  pc_out_d   = pc_q;
                  pc_plus4_d = pc_q + 32'd4;
                  valid_d    = 1'b1;
                  pc_d       = pc_q + 32'd4;
               end else begin
                  buf_instr_d = IMEM_READDATA;
                  buf_pc_d    = pc_q;
                  pc_d        = pc_q + 32'd4;
                  state_d     = HOLD;
               end
            end
         end

         HOLD: begin
            if (BRANCH_TAKEN) begin
               pc_d    = target;
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               state_d = FETCH;
            end else if (!STALL) begin
               instr_d    = buf_instr_q;
               pc_out_d   = buf_pc_q;
               pc_plus4_d = buf_pc_q + 32'd4;
               valid_d    = 1'b1;
               state_d    = FETCH;
            end
         end

         DROP: begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if (BRANCH_TAKEN) begin
               redir_pc_d = target;
            end
            // A redirect arriving on the same edge the stale word returns is the newest target.
            if (!IMEM_BUSYWAIT) begin
               pc_d    = BRANCH_TAKEN ? target : redir_pc_q;
               state_d = FETCH;
            end
         end

         default: state_d = FETCH;
      endcase
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: memory returns word==address,
// per-cycle vector table plus a hand-written mid-fetch reset sequence.
module tb_instruction_fetch_unit;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        STALL;
   logic        BRANCH_TAKEN;
   logic [31:0] BRANCH_TARGET;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_READ;
   logic        IMEM_BUSYWAIT;
   logic [31:0] IMEM_READDATA;
   logic [31:0] INSTRUCTION;
   logic [31:0] PC_OUT;
   logic [31:0] PC_PLUS4;
   logic        VALID;

   int unsigned tests_run = 0;
   int unsigned tests_failed = 0;

   localparam logic [31:0] NOP = 32'h00000013;

   always #5 CLK = ~CLK;

   assign IMEM_READDATA = IMEM_ADDR;

   instruction_fetch_unit #(
      .RESET_PC (32'h00000000),
      .NOP_INSTR(32'h00000013)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .STALL        (STALL),
      .BRANCH_TAKEN (BRANCH_TAKEN),
      .BRANCH_TARGET(BRANCH_TARGET),
      .IMEM_ADDR    (IMEM_ADDR),
      .IMEM_READ    (IMEM_READ),
      .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
      .IMEM_READDATA(IMEM_READDATA),
      .INSTRUCTION  (INSTRUCTION),
      .PC_OUT       (PC_OUT),
      .PC_PLUS4     (PC_PLUS4),
      .VALID        (VALID)
   );

   typedef struct {
      logic        stall;
      logic        bt;
      logic [31:0] tgt;
      logic        busy;
      logic        exp_read;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs [29];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t, input logic w,
                               input logic r, input logic [31:0] a,
                               input logic v, input logic [31:0] i, input logic [31:0] p);
      vec_t x;
      x.stall = s; x.bt = b; x.tgt = t; x.busy = w;
      x.exp_read = r; x.exp_addr = a;
      x.exp_valid = v; x.exp_instr = i; x.exp_pc = p;
      return x;
   endfunction

   initial begin
      //            stall bt tgt            busy  read addr          valid instr         pc
      vecs[0]  = mk(0, 0, 32'h0,          0,    1, 32'h00000000,  1, 32'h00000000, 32'h00000000);
      vecs[1]  = mk(0, 0, 32'h0,          0,    1, 32'h00000004,  1, 32'h00000004, 32'h00000004);
      vecs[2]  = mk(0, 0, 32'h0,          0,    1, 32'h00000008,  1, 32'h00000008, 32'h00000008);
      vecs[3]  = mk(0, 0, 32'h0,          0,    1, 32'h0000000C,  1, 32'h0000000C, 32'h0000000C);
      // two wait cycles at 0x10
      vecs[4]  = mk(0, 0, 32'h0,          1,    1, 32'h00000010,  0, NOP,          32'h0);
      vecs[5]  = mk(0, 0, 32'h0,          1,    1, 32'h00000010,  0, NOP,          32'h0);
      vecs[6]  = mk(0, 0, 32'h0,          0,    1, 32'h00000010,  1, 32'h00000010, 32'h00000010);
      // stall while word 0x14 returns, held three cycles
      vecs[7]  = mk(1, 0, 32'h0,          0,    1, 32'h00000014,  1, 32'h00000010, 32'h00000010);
      vecs[8]  = mk(1, 0, 32'h0,          0,    0, 32'h0,         1, 32'h00000010, 32'h00000010);
      vecs[9]  = mk(1, 0, 32'h0,          0,    0, 32'h0,         1, 32'h00000010, 32'h00000010);
      vecs[10] = mk(0, 0, 32'h0,          0,    0, 32'h0,         1, 32'h00000014, 32'h00000014);
      vecs[11] = mk(0, 0, 32'h0,          0,    1, 32'h00000018,  1, 32'h00000018, 32'h00000018);
      // redirect to 0x103 during 3-cycle busy fetch of 0x1C
      vecs[12] = mk(0, 1, 32'h00000103,   1,    1, 32'h0000001C,  0, NOP,          32'h0);
      vecs[13] = mk(0, 0, 32'h0,          1,    1, 32'h0000001C,  0, NOP,          32'h0);
      vecs[14] = mk(0, 0, 32'h0,          1,    1, 32'h0000001C,  0, NOP,          32'h0);
      vecs[15] = mk(0, 0, 32'h0,          0,    1, 32'h0000001C,  0, NOP,          32'h0);
      vecs[16] = mk(0, 0, 32'h0,          0,    1, 32'h00000100,  1, 32'h00000100, 32'h00000100);
      // redirect together with stall while in HOLD
      vecs[17] = mk(1, 0, 32'h0,          0,    1, 32'h00000104,  1, 32'h00000100, 32'h00000100);
      vecs[18] = mk(1, 1, 32'h00000200,   0,    0, 32'h0,         0, NOP,          32'h0);
      vecs[19] = mk(0, 0, 32'h0,          0,    1, 32'h00000200,  1, 32'h00000200, 32'h00000200);
      // redirect on data return, to a misaligned top-of-memory target
      vecs[20] = mk(0, 1, 32'hFFFFFFFE,   0,    1, 32'h00000204,  0, NOP,          32'h0);
      vecs[21] = mk(0, 0, 32'h0,          0,    1, 32'hFFFFFFFC,  1, 32'hFFFFFFFC, 32'hFFFFFFFC);
      vecs[22] = mk(0, 0, 32'h0,          0,    1, 32'h00000000,  1, 32'h00000000, 32'h00000000);
      // second redirect while dropping overrides the first
      vecs[23] = mk(0, 1, 32'h00000300,   1,    1, 32'h00000004,  0, NOP,          32'h0);
      vecs[24] = mk(0, 1, 32'h00000400,   1,    1, 32'h00000004,  0, NOP,          32'h0);
      vecs[25] = mk(0, 0, 32'h0,          0,    1, 32'h00000004,  0, NOP,          32'h0);
      vecs[26] = mk(0, 0, 32'h0,          0,    1, 32'h00000400,  1, 32'h00000400, 32'h00000400);
      // stall during a busy cycle holds outputs rather than bubbling
      vecs[27] = mk(1, 0, 32'h0,          1,    1, 32'h00000404,  1, 32'h00000400, 32'h00000400);
      vecs[28] = mk(0, 0, 32'h0,          0,    1, 32'h00000404,  1, 32'h00000404, 32'h00000404);

      RESET = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0; IMEM_BUSYWAIT = 1'b0;
      @(posedge CLK);
      #1;
      chk("reset VALID", {31'b0, VALID}, 32'd0);
      chk("reset INSTRUCTION", INSTRUCTION, NOP);
      chk("reset PC_OUT", PC_OUT, 32'd0);
      chk("reset PC_PLUS4", PC_PLUS4, 32'd0);
      chk("reset IMEM_READ", {31'b0, IMEM_READ}, 32'd0);
      @(negedge CLK);
      RESET = 1'b0;

      for (int i = 0; i < 29; i++) begin
         STALL         = vecs[i].stall;
         BRANCH_TAKEN  = vecs[i].bt;
         BRANCH_TARGET = vecs[i].tgt;
         IMEM_BUSYWAIT = vecs[i].busy;
         #1;
         chk($sformatf("v%0d IMEM_READ", i), {31'b0, IMEM_READ}, {31'b0, vecs[i].exp_read});
         if (vecs[i].exp_read)
            chk($sformatf("v%0d IMEM_ADDR", i), IMEM_ADDR, vecs[i].exp_addr);
         @(posedge CLK);
         #1;
         chk($sformatf("v%0d VALID", i), {31'b0, VALID}, {31'b0, vecs[i].exp_valid});
         chk($sformatf("v%0d INSTRUCTION", i), INSTRUCTION, vecs[i].exp_instr);
         if (vecs[i].exp_valid) begin
            chk($sformatf("v%0d PC_OUT", i), PC_OUT, vecs[i].exp_pc);
            chk($sformatf("v%0d PC_PLUS4", i), PC_PLUS4, vecs[i].exp_pc + 32'd4);
         end
         @(negedge CLK);
      end

      // Reset in the middle of a busy fetch of 0x408 (stalled, so VALID is still 1).
      STALL = 1'b1; BRANCH_TAKEN = 1'b0; IMEM_BUSYWAIT = 1'b1;
      @(posedge CLK);
      #1;
      chk("pre-reset VALID", {31'b0, VALID}, 32'd1);
      chk("pre-reset IMEM_ADDR", IMEM_ADDR, 32'h00000408);
      #2;
      RESET = 1'b1;
      #1;
      chk("async reset VALID", {31'b0, VALID}, 32'd0);
      chk("async reset IMEM_READ", {31'b0, IMEM_READ}, 32'd0);
      chk("async reset INSTRUCTION", INSTRUCTION, NOP);
      @(negedge CLK);
      RESET = 1'b0; STALL = 1'b0; IMEM_BUSYWAIT = 1'b0;
      #1;
      chk("post-reset IMEM_READ", {31'b0, IMEM_READ}, 32'd1);
      chk("post-reset IMEM_ADDR", IMEM_ADDR, 32'h00000000);
      @(posedge CLK);
      #1;
      chk("post-reset VALID", {31'b0, VALID}, 32'd1);
      chk("post-reset PC_OUT", PC_OUT, 32'h00000000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
